uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_send transmitter between N_REQ byte-stream requesters (camera status, command echo, debug counters).
- Round-robin arbitration with per-grant burst lock, so a requester's packet is not interleaved with another's.
- Drives the sender's DATA/DATA_READY pair and tracks its IDLE output to pace bytes.
- Sits between the requesters and uart_send in the CLK1 domain, replacing ad-hoc edge-detect pacing logic in the top level.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes sent per grant before forced rotation (1..255).
- BUSY_TIMEOUT, 4096, CLK cycles to wait for IDLE to fall after a launch before declaring an error.

Ports:
- CLK  in  1  system clock (CLK1 domain).
- RST  in  1  reset.
- REQ_VALID  in  N_REQ  requester i has a byte on its REQ_DATA slice.
- REQ_DATA  in  8*N_REQ  byte of requester i in bits [8i+7:8i].
- REQ_LAST  in  N_REQ  current byte of requester i ends its packet.
- REQ_ACK  out  N_REQ  one-cycle pulse: byte of requester i captured.
- TX_DATA  out  8  byte to uart_send DATA.
- TX_DATA_READY  out  1  one-cycle launch pulse to uart_send DATA_READY.
- TX_IDLE  in  1  uart_send IDLE.
- GRANT  out  N_REQ  one-hot current owner, 0 when none.
- BUSY  out  1  a packet/burst is in progress.
- ERR  out  1  one-cycle pulse on BUSY_TIMEOUT expiry.

Behaviour:
- Reset: one clock; reset is synchronous and active-high (RST sampled on posedge CLK).
  - All outputs 0. State ARB. RR pointer = 0, so index 0 has highest priority. Burst and timeout counters 0.
  - RST mid-transfer aborts immediately. No ACK or launch pulse is issued in the reset cycle.
- States: ARB, LOAD, LAUNCH, WAIT_BUSY, WAIT_IDLE.
- ARB:
  - If GRANT==0, pick the first REQ_VALID bit searching from the RR pointer upward with wrap. Set GRANT and BUSY=1.
  - Proceed to LOAD only when TX_IDLE=1. A new grant is registered even if TX_IDLE=0.
  - If GRANT!=0 (lock held) and the owner's REQ_VALID=1 and TX_IDLE=1, go to LOAD.
- LOAD (1 cycle):
  - TX_DATA <= owner's REQ_DATA; REQ_ACK[owner] pulses.
  - Burst counter increments. Latch last_flag = REQ_LAST[owner].
- LAUNCH (1 cycle): TX_DATA_READY=1. Timeout counter cleared.
- WAIT_BUSY:
  - Wait for TX_IDLE=0, then go to WAIT_IDLE.
  - Timeout counter increments each cycle. On reaching BUSY_TIMEOUT: ERR pulses and the grant is released (same as end of burst).
- WAIT_IDLE: on TX_IDLE=1, go to ARB.
  - The grant is released when last_flag=1, or burst counter == MAX_BURST, or the owner's REQ_VALID=0 at this cycle.
  - On release: GRANT=0, BUSY=0, burst counter=0, RR pointer = owner+1 mod N_REQ.
- TX_DATA holds its value from LOAD until the next LOAD. It is never changed while the sender is busy.
- Latency: REQ_VALID seen in ARB at cycle t with TX_IDLE=1 → REQ_ACK at t+1 → TX_DATA_READY at t+2.
- Owner that drops REQ_VALID while locked: treated as end of packet at the next WAIT_IDLE→ARB boundary. If it drops while in ARB with the lock held, the grant is released in ARB that cycle and the pointer advances.
- Requesters must hold REQ_DATA/REQ_LAST stable while REQ_VALID=1 and unacked. A REQ_VALID change in the LOAD cycle is ignored.
- No requests: stay in ARB, GRANT=0, no pulses.
- Burst counter is 8-bit and saturates at MAX_BURST; it never wraps.

Decomposition:
- Shared package (uart_pkg): state encoding constants, byte width 8, default MAX_BURST/BUSY_TIMEOUT.
- Sub-module rr_pick: combinational round-robin one-hot selector (inputs: request vector, pointer; output: one-hot grant). Reusable for later sensor-register arbiters.
- Remainder is the FSM and counters in uart_tx_arbiter.

Test Plan:
- Single byte: REQ_VALID[1]=1, REQ_DATA=0x41, REQ_LAST=1, TX_IDLE=1 → GRANT=0010; ACK[1] at t+1; TX_DATA_READY at t+2 with TX_DATA=0x41; after sender model IDLE low→high, GRANT=0, pointer=2.
- Round-robin: all 4 requesters valid, each with single-byte packets 0x30..0x33 → launch order 0,1,2,3,0. From reset pointer, order after req 2 is 3,0,1.
- Burst lock: req0 sends 3-byte packet 0xA0,0xA1,0xA2 (LAST on 3rd) while req1 is valid → all three bytes precede req1's byte; GRANT stays 0001 throughout.
- MAX_BURST=2, req0 streams 5 bytes with no LAST, req1 valid → order 0,0,1,0,0,...
- Timeout: sender model never drops IDLE, BUSY_TIMEOUT=8 → ERR pulses exactly 8 cycles after LAUNCH; grant released; next requester served.
- RST asserted in WAIT_IDLE → next cycle all outputs 0, state ARB, pointer 0. No spurious TX_DATA_READY after RST deasserts until a new request arrives.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Holds the FSM state encoding and the default pacing parameters.
package uart_pkg;

  localparam int BYTE_W           = 8;
  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_BUSY_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    ST_ARB,
    ST_LOAD,
    ST_LAUNCH,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot grant of the first
// request at or after the pointer, searching upward with wrap.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic [PW:0] w_idx;
  logic        w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(N)) begin
        w_idx = w_idx - (PW+1)'(N);
      end
      if (!w_found && i_req[w_idx[PW-1:0]]) begin
        o_gnt[w_idx[PW-1:0]] = 1'b1;
        w_found              = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked sharing of one uart_send between N_REQ
// byte-stream requesters, paced by the sender's IDLE output.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [N_REQ-1:0]          REQ_VALID,
  input  logic [BYTE_W*N_REQ-1:0]   REQ_DATA,
  input  logic [N_REQ-1:0]          REQ_LAST,
  output logic [N_REQ-1:0]          REQ_ACK,
  output logic [BYTE_W-1:0]         TX_DATA,
  output logic                      TX_DATA_READY,
  input  logic                      TX_IDLE,
  output logic [N_REQ-1:0]          GRANT,
  output logic                      BUSY,
  output logic                      ERR
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t        r_state, w_state_n;
  logic [N_REQ-1:0]  r_grant, w_grant_n;
  logic              r_busy, w_busy_n;
  logic [7:0]        r_burst, w_burst_n;
  logic [PW-1:0]     r_ptr, w_ptr_n;
  logic [TW-1:0]     r_tmo, w_tmo_n;
  logic              r_last, w_last_n;
  logic [BYTE_W-1:0] r_tx_data, w_data_n;

  logic [N_REQ-1:0]  w_pick;
  logic [N_REQ-1:0]  w_ack;
  logic              w_rdy, w_err, w_rel;
  logic [PW-1:0]     w_owner, w_ptr_inc;
  logic [BYTE_W-1:0] w_odata;
  logic              w_ovalid, w_olast;

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_req (REQ_VALID),
    .i_ptr (r_ptr),
    .o_gnt (w_pick)
  );

  always_comb begin
    w_owner = '0;
    w_odata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        w_owner = PW'(i);
        w_odata = REQ_DATA[BYTE_W*i +: BYTE_W];
      end
    end
  end

  assign w_ovalid  = |(REQ_VALID & r_grant);
  assign w_olast   = |(REQ_LAST & r_grant);
  assign w_ptr_inc = (w_owner == PW'(N_REQ-1)) ? '0
                   : w_owner + PW'(1);

  always_comb begin
    w_state_n = r_state;
    w_grant_n = r_grant;
    w_busy_n  = r_busy;
    w_burst_n = r_burst;
    w_ptr_n   = r_ptr;
    w_tmo_n   = r_tmo;
    w_last_n  = r_last;
    w_data_n  = r_tx_data;
    w_ack     = '0;
    w_rdy     = 1'b0;
    w_err     = 1'b0;
    w_rel     = 1'b0;
    unique case (r_state)
      ST_ARB: begin
        if (r_grant == '0) begin
          if (|REQ_VALID) begin
            w_grant_n = w_pick;
            w_busy_n  = 1'b1;
            if (TX_IDLE) w_state_n = ST_LOAD;
          end
        end else if (!w_ovalid) begin
          w_rel = 1'b1;
        end else if (TX_IDLE) begin
          w_state_n = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_data_n = w_odata;
        w_ack    = r_grant;
        w_last_n = w_olast;
        if (r_burst < 8'(MAX_BURST)) begin
          w_burst_n = r_burst + 8'd1;
        end
        w_state_n = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        w_rdy     = 1'b1;
        w_tmo_n   = '0;
        w_state_n = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!TX_IDLE) begin
          w_state_n = ST_WAIT_IDLE;
        end else if (r_tmo == TW'(BUSY_TIMEOUT-1)) begin
          // Sender never took the byte: abandon this owner.
          w_err     = 1'b1;
          w_rel     = 1'b1;
          w_state_n = ST_ARB;
        end else begin
          w_tmo_n = r_tmo + TW'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (TX_IDLE) begin
          w_state_n = ST_ARB;
          if (r_last || !w_ovalid ||
              r_burst == 8'(MAX_BURST)) begin
            w_rel = 1'b1;
          end
        end
      end
      default: w_state_n = ST_ARB;
    endcase
    if (w_rel) begin
      w_grant_n = '0;
      w_busy_n  = 1'b0;
      w_burst_n = '0;
      w_ptr_n   = w_ptr_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= ST_ARB;
      r_grant   <= '0;
      r_busy    <= 1'b0;
      r_burst   <= '0;
      r_ptr     <= '0;
      r_tmo     <= '0;
      r_last    <= 1'b0;
      r_tx_data <= '0;
    end else begin
      r_state   <= w_state_n;
      r_grant   <= w_grant_n;
      r_busy    <= w_busy_n;
      r_burst   <= w_burst_n;
      r_ptr     <= w_ptr_n;
      r_tmo     <= w_tmo_n;
      r_last    <= w_last_n;
      r_tx_data <= w_data_n;
    end
  end

  // Pulses are masked while RST is high so an abort never leaks one.
  assign REQ_ACK       = RST ? '0 : w_ack;
  assign TX_DATA_READY = RST ? 1'b0 : w_rdy;
  assign ERR           = RST ? 1'b0 : w_err;
  assign TX_DATA       = r_tx_data;
  assign GRANT         = r_grant;
  assign BUSY          = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with requester and sender models.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_last = '0;
  logic [31:0] req_data = '0;
  logic        tx_idle = 1'b1;

  logic [3:0] a_ack, a_gnt, b_ack, b_gnt;
  logic [7:0] a_txd, b_txd;
  logic       a_rdy, a_busy, a_err, b_rdy, b_busy, b_err;

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(16), .BUSY_TIMEOUT(8)) u_dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_LAST(req_last), .REQ_ACK(a_ack), .TX_DATA(a_txd),
    .TX_DATA_READY(a_rdy), .TX_IDLE(tx_idle), .GRANT(a_gnt),
    .BUSY(a_busy), .ERR(a_err)
  );

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(2), .BUSY_TIMEOUT(8)) u_dut_b (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_DATA(req_data),
    .REQ_LAST(req_last), .REQ_ACK(b_ack), .TX_DATA(b_txd),
    .TX_DATA_READY(b_rdy), .TX_IDLE(tx_idle), .GRANT(b_gnt),
    .BUSY(b_busy), .ERR(b_err)
  );

  int n_chk = 0, n_err = 0, cyc = 0;
  bit sel = 0, stuck = 0;

  logic [3:0] s_ack, s_gnt;
  logic [7:0] s_txd;
  logic       s_rdy, s_busy, s_err;

  logic [7:0] q_data[4][8];
  bit         q_last[4][8];
  int         q_n[4], q_pos[4];

  int   scnt = 0;
  logic idle_m = 1'b1;

  logic [7:0] lg_data[64];
  logic [3:0] lg_gnt[64];
  int         lg_cyc[64];
  int         lg_n = 0;
  int         err_cyc = -1, err_cnt = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < 4; i++) s += q_n[i] - q_pos[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (q_pos[i] < q_n[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = q_data[i][q_pos[i]];
        req_last[i]        = q_last[i][q_pos[i]];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
    tx_idle = idle_m;
    #1;
    s_ack  = sel ? b_ack  : a_ack;
    s_gnt  = sel ? b_gnt  : a_gnt;
    s_txd  = sel ? b_txd  : a_txd;
    s_rdy  = sel ? b_rdy  : a_rdy;
    s_busy = sel ? b_busy : a_busy;
    s_err  = sel ? b_err  : a_err;
    cyc++;
    for (int i = 0; i < 4; i++) if (s_ack[i]) q_pos[i]++;
    if (s_rdy && lg_n < 64) begin
      lg_data[lg_n] = s_txd;
      lg_gnt[lg_n]  = s_gnt;
      lg_cyc[lg_n]  = cyc;
      lg_n++;
    end
    if (s_err) begin
      err_cnt++;
      if (err_cyc < 0) err_cyc = cyc;
    end
    if (rst) begin
      idle_m = 1'b1;
      scnt   = 0;
    end else if (scnt > 0) begin
      scnt--;
      if (scnt == 0) idle_m = 1'b1;
    end else if (s_rdy && !stuck) begin
      idle_m = 1'b0;
      scnt   = 3;
    end
  endtask

  // lmode: 0 no LAST, 1 LAST on final byte, 2 LAST on every byte
  task automatic load(int i, int n, logic [7:0] base, int lmode);
    q_n[i]   = n;
    q_pos[i] = 0;
    for (int k = 0; k < n; k++) begin
      q_data[i][k] = 8'(base + k);
      q_last[i][k] = (lmode == 2) || (lmode == 1 && k == n - 1);
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) begin
      q_n[i]   = 0;
      q_pos[i] = 0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    lg_n    = 0;
    err_cyc = -1;
    err_cnt = 0;
  endtask

  task automatic drain(string tag);
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      tick();
      if (!s_busy && idle_m && scnt == 0 && pending() == 0) done = 1;
    end
    check({tag, "_drain"}, 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      q_n[i]   = 0;
      q_pos[i] = 0;
    end

    // reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt",  32'(s_gnt),  32'h0);
    check("rst_busy", 32'(s_busy), 32'h0);
    check("rst_ack",  32'(s_ack),  32'h0);
    check("rst_rdy",  32'(s_rdy),  32'h0);
    check("rst_err",  32'(s_err),  32'h0);
    check("rst_txd",  32'(s_txd),  32'h0);
    rst = 1'b0;
    tick();
    check("idle_gnt", 32'(s_gnt), 32'h0);

    // single byte from requester 1
    load(1, 1, 8'h41, 1);
    tick();
    check("t1_gnt0", 32'(s_gnt), 32'h0);
    tick();
    check("t1_gnt",  32'(s_gnt),  32'h2);
    check("t1_ack",  32'(s_ack),  32'h2);
    check("t1_busy", 32'(s_busy), 32'h1);
    tick();
    check("t1_rdy",  32'(s_rdy), 32'h1);
    check("t1_txd",  32'(s_txd), 32'h41);
    check("t1_ack1", 32'(s_ack), 32'h0);
    drain("t1");
    check("t1_gnt_rel",  32'(s_gnt),  32'h0);
    check("t1_busy_rel", 32'(s_busy), 32'h0);

    // pointer now 2: order 3,0,1
    lg_n = 0;
    load(0, 1, 8'h10, 1);
    load(1, 1, 8'h11, 1);
    load(3, 1, 8'h13, 1);
    drain("t2");
    check("t2_n",  32'(lg_n),       32'd3);
    check("t2_d0", 32'(lg_data[0]), 32'h13);
    check("t2_d1", 32'(lg_data[1]), 32'h10);
    check("t2_d2", 32'(lg_data[2]), 32'h11);
    check("t2_g0", 32'(lg_gnt[0]),  32'h8);

    // round robin from reset pointer
    do_reset();
    load(0, 2, 8'h30, 2);
    q_data[0][1] = 8'h34;
    load(1, 1, 8'h31, 1);
    load(2, 1, 8'h32, 1);
    load(3, 1, 8'h33, 1);
    drain("rr");
    check("rr_n",  32'(lg_n),       32'd5);
    check("rr_d0", 32'(lg_data[0]), 32'h30);
    check("rr_d1", 32'(lg_data[1]), 32'h31);
    check("rr_d2", 32'(lg_data[2]), 32'h32);
    check("rr_d3", 32'(lg_data[3]), 32'h33);
    check("rr_d4", 32'(lg_data[4]), 32'h34);

    // burst lock
    do_reset();
    load(0, 3, 8'hA0, 1);
    load(1, 1, 8'hB1, 1);
    drain("lk");
    check("lk_n",  32'(lg_n),       32'd4);
    check("lk_d0", 32'(lg_data[0]), 32'hA0);
    check("lk_d1", 32'(lg_data[1]), 32'hA1);
    check("lk_d2", 32'(lg_data[2]), 32'hA2);
    check("lk_d3", 32'(lg_data[3]), 32'hB1);
    check("lk_g1", 32'(lg_gnt[1]),  32'h1);
    check("lk_g2", 32'(lg_gnt[2]),  32'h1);
    check("lk_g3", 32'(lg_gnt[3]),  32'h2);

    // MAX_BURST=2 forces rotation
    sel = 1;
    do_reset();
    load(0, 5, 8'hC0, 0);
    load(1, 1, 8'hD0, 1);
    drain("mb");
    check("mb_n",  32'(lg_n),       32'd6);
    check("mb_d0", 32'(lg_data[0]), 32'hC0);
    check("mb_d1", 32'(lg_data[1]), 32'hC1);
    check("mb_d2", 32'(lg_data[2]), 32'hD0);
    check("mb_d3", 32'(lg_data[3]), 32'hC2);
    check("mb_d4", 32'(lg_data[4]), 32'hC3);
    check("mb_d5", 32'(lg_data[5]), 32'hC4);
    sel = 0;

    // busy timeout
    do_reset();
    stuck = 1;
    load(2, 1, 8'hE2, 1);
    load(3, 1, 8'hE3, 1);
    for (int k = 0; k < 40 && err_cnt == 0; k++) tick();
    check("to_seen", 32'(lg_n >= 1 && err_cnt == 1), 32'd1);
    check("to_dly",  32'(err_cyc - lg_cyc[0]),       32'd8);
    tick();
    check("to_gnt_rel", 32'(s_gnt), 32'h0);
    stuck = 0;
    drain("to");
    check("to_errs", 32'(err_cnt),    32'd1);
    check("to_n",    32'(lg_n),       32'd2);
    check("to_next", 32'(lg_data[1]), 32'hE3);

    // reset while waiting for IDLE
    do_reset();
    load(1, 1, 8'h77, 1);
    for (int k = 0; k < 20 && lg_n == 0; k++) tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("ra_gnt",  32'(s_gnt),  32'h0);
    check("ra_busy", 32'(s_busy), 32'h0);
    check("ra_ack",  32'(s_ack),  32'h0);
    check("ra_rdy",  32'(s_rdy),  32'h0);
    check("ra_err",  32'(s_err),  32'h0);
    check("ra_txd",  32'(s_txd),  32'h0);
    lg_n = 0;
    repeat (10) tick();
    check("ra_quiet", 32'(lg_n), 32'd0);
    load(0, 1, 8'h60, 1);
    load(3, 1, 8'h63, 1);
    drain("ra");
    check("ra_d0", 32'(lg_data[0]), 32'h60);
    check("ra_d1", 32'(lg_data[1]), 32'h63);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
